path_addr_sched: RTL and testbench
==================================

// Module: path_addr_sched
// PURPOSE
//  Shares the path address generator between two requesters: real accesses (Req0) and dummy/background evictions (Req1).
//  Sequences each granted access as a read-path phase, then a write-back phase to the same leaf.
//  The write-back phase is issued only after the stash signals WriteGo.
//  Sits between the backend controller/eviction logic and the address generator feeding the DRAM command port.
// PARAMETERS
//  ORAML    10  tree depth; leaf width
//  GuardCyc 1   cycles after AG_Start during which AG_Ready is ignored (generator drops Ready one cycle after Start)
// PORTS
//  Clock      in   1      system clock
//  Reset      in   1      synchronous, active-high reset
//  Req0Valid  in   1      real-access request
//  Req0Ready  out  1      Req0 accepted this cycle (valid&ready)
//  Req0Leaf   in   ORAML  leaf for Req0
//  Req0BH     in   1      1 = header-only access, 0 = full buckets
//  Req1Valid  in   1      dummy/eviction request
//  Req1Ready  out  1      Req1 accepted this cycle
//  Req1Leaf   in   ORAML  leaf for Req1
//  Req1BH     in   1      header/bucket select for Req1
//  AG_Start   out  1      one-cycle start pulse to the address generator
//  AG_RW      out  1      1 = read, 0 = write; valid with AG_Start
//  AG_BH      out  1      header select; valid with AG_Start
//  AG_Leaf    out  ORAML  leaf; valid with AG_Start
//  AG_Ready   in   1      address generator idle (path complete)
//  WriteGo    in   1      stash ready to supply write-back data
//  Busy       out  1      access in flight (state != IDLE)
//  GrantId    out  1      owner of the current access (0/1)
//  AccDone    out  1      one-cycle pulse when write-back path completes
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; latched leaf/BH/GrantId 0; rr pointer 0.
//    Reset mid-access abandons the access with no AccDone; the generator is reset by the same Reset.
//  States: IDLE -> RD_ISSUE -> RD_WAIT -> WR_HOLD -> WR_ISSUE -> WR_WAIT -> IDLE.
//  IDLE: if any ReqNValid, grant per arbitration and pulse ReqNReady the same cycle; latch Leaf, BH, GrantId; go to RD_ISSUE.
//  RD_ISSUE: wait for AG_Ready=1, then assert AG_Start=1, AG_RW=1 for exactly one cycle; load guard counter = GuardCyc; go to RD_WAIT.
//  RD_WAIT: decrement guard while nonzero, ignoring AG_Ready; once guard = 0 and AG_Ready=1, go to WR_HOLD.
//  WR_HOLD: wait for WriteGo=1; WriteGo may arrive before the read completes (sticky flag set in any state after grant, cleared at WR_ISSUE).
//  WR_ISSUE: like RD_ISSUE with AG_RW=0, same leaf and BH as the read phase.
//  WR_WAIT: as RD_WAIT; on exit pulse AccDone=1 for one cycle and go to IDLE.
//  IDLE may grant a new request the same cycle AccDone pulses.
//  AG_RW/AG_BH/AG_Leaf are held stable from grant to AccDone; AG_Start never pulses outside *_ISSUE.
//  Req*Ready is 0 outside IDLE; at most one Req*Ready per cycle.
//  Requesters hold Valid/Leaf/BH until Ready; the block never drops a granted request.
// CONFIGURATION
//  PATHSCHED_RR_EN defined: round-robin arbitration.
//    On both valid, grant the port != last granted; pointer updates on each grant.
//  Undefined: fixed priority, Req0 always wins; Req1 is granted only when Req0Valid=0.
// STRUCTURE
//  Shared package/header: state encoding localparams (3-bit); DDR3 read/write command constants reused for AG_RW.
//  Sub-module: path_sched_arb (2-way arbiter, combinational grant plus rr pointer register) so the FSM stays arbitration-agnostic.
// TESTING
//  1) Req0 leaf=0x155, BH=0, WriteGo high early -> one AG_Start RW=1, then one AG_Start RW=0, both leaf 0x155; AccDone once.
//  2) WriteGo asserted 20 cycles after read path done -> block stays in WR_HOLD; write AG_Start exactly 1 cycle after WriteGo.
//  3) Req0 and Req1 valid every cycle for 4 accesses, RR_EN -> grant order 0,1,0,1.
//     Without RR_EN -> 0,0,0,0; Req1Ready never high.
//  4) AG_Ready held 0 for 50 cycles in RD_ISSUE -> no AG_Start; issues the cycle AG_Ready returns.
//  5) Reset asserted in RD_WAIT -> next cycle all outputs 0, state IDLE, no AccDone; a new request proceeds normally.
//  6) Req1 BH=1 leaf=0x3FF -> AG_BH=1 on both phases, leaf 0x3FF (max); no width truncation.

Source files
------------

// File: rtl/path_addr_sched_pkg.sv
// Shared definitions for the path address scheduler: FSM state encoding,
// read/write command codes driven on AG_RW, and the guard counter sizing helper.
package path_addr_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_HOLD  = 3'd3,
        ST_WR_ISSUE = 3'd4,
        ST_WR_WAIT  = 3'd5
    } sched_state_t;

    // DDR3 command direction codes, reused as the AG_RW encoding
    localparam logic DDR3_CMD_READ  = 1'b1;
    localparam logic DDR3_CMD_WRITE = 1'b0;

    function automatic int guard_width(input int cyc);
        return (cyc > 0) ? $clog2(cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/path_sched_arb.sv
// Two-way request arbiter. Build option PATHSCHED_RR_EN selects round-robin;
// otherwise Req0 has fixed priority. The last-grant register doubles as the owner id.
module path_sched_arb (
    input  logic clk,
    input  logic reset,
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic grant_en,
    output logic gnt0,
    output logic gnt1,
    output logic owner
);

    logic owner_r;
    logic tie_pick1_s;

    // Combinational grant; on a tie the round-robin build favours the port not granted last
    always_comb begin
`ifdef PATHSCHED_RR_EN
        tie_pick1_s = ~owner_r;
`else
        tie_pick1_s = 1'b0;
`endif
        gnt1 = grant_en & req1_valid & (~req0_valid | tie_pick1_s);
        gnt0 = grant_en & req0_valid & ~gnt1;
    end

    // Last-granted port, updated on every grant
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r <= 1'b0;
        end else if (gnt1) begin
            owner_r <= 1'b1;
        end else if (gnt0) begin
            owner_r <= 1'b0;
        end else begin
            owner_r <= owner_r;
        end
    end

    assign owner = owner_r;

endmodule

// File: rtl/path_addr_sched.sv
// Path address scheduler: arbitrates real and eviction requests onto the shared
// address generator, running a read path then a write-back path per access.
// Build option PATHSCHED_RR_EN enables round-robin arbitration (see path_sched_arb).
module path_addr_sched
    import path_addr_sched_pkg::*;
#(
    parameter int ORAML    = 10,
    parameter int GuardCyc = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Req0Valid,
    output logic             Req0Ready,
    input  logic [ORAML-1:0] Req0Leaf,
    input  logic             Req0BH,
    input  logic             Req1Valid,
    output logic             Req1Ready,
    input  logic [ORAML-1:0] Req1Leaf,
    input  logic             Req1BH,
    output logic             AG_Start,
    output logic             AG_RW,
    output logic             AG_BH,
    output logic [ORAML-1:0] AG_Leaf,
    input  logic             AG_Ready,
    input  logic             WriteGo,
    output logic             Busy,
    output logic             GrantId,
    output logic             AccDone
);

    localparam int GW = guard_width(GuardCyc);

    sched_state_t     state_r, state_nx_s;
    logic [GW-1:0]    guard_r, guard_nx_s;
    logic [ORAML-1:0] leaf_r;
    logic             bh_r, rw_r, wgo_r, done_r;
    logic             done_nx_s, start_s, idle_s, grant_s, go_write_s;
    logic             gnt0_s, gnt1_s, owner_s;

    path_sched_arb u_arb (
        .clk        (Clock),
        .reset      (Reset),
        .req0_valid (Req0Valid),
        .req1_valid (Req1Valid),
        .grant_en   (idle_s),
        .gnt0       (gnt0_s),
        .gnt1       (gnt1_s),
        .owner      (owner_s)
    );

    // Next-state, issue strobe and guard countdown
    always_comb begin
        state_nx_s = state_r;
        guard_nx_s = guard_r;
        done_nx_s  = 1'b0;
        start_s    = 1'b0;
        idle_s     = (state_r == ST_IDLE);
        grant_s    = gnt0_s | gnt1_s;
        go_write_s = WriteGo | wgo_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) state_nx_s = ST_RD_ISSUE;
                else         state_nx_s = ST_IDLE;
            end
            ST_RD_ISSUE, ST_WR_ISSUE: begin
                if (AG_Ready) begin
                    start_s    = 1'b1;
                    guard_nx_s = GW'(GuardCyc);
                    state_nx_s = (state_r == ST_RD_ISSUE) ? ST_RD_WAIT : ST_WR_WAIT;
                end else begin
                    state_nx_s = state_r;
                end
            end
            // Ready is still high right after Start, so it is ignored until the guard expires
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (guard_r != {GW{1'b0}}) begin
                    guard_nx_s = guard_r - GW'(1);
                end else if (AG_Ready) begin
                    state_nx_s = (state_r == ST_RD_WAIT) ? ST_WR_HOLD : ST_IDLE;
                    done_nx_s  = (state_r == ST_WR_WAIT);
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_WR_HOLD: begin
                if (go_write_s) state_nx_s = ST_WR_ISSUE;
                else            state_nx_s = ST_WR_HOLD;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, guard, latched request fields and completion pulse
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            guard_r <= {GW{1'b0}};
            leaf_r  <= {ORAML{1'b0}};
            bh_r    <= 1'b0;
            rw_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            guard_r <= guard_nx_s;
            done_r  <= done_nx_s;
            if (grant_s) begin
                leaf_r <= gnt1_s ? Req1Leaf : Req0Leaf;
                bh_r   <= gnt1_s ? Req1BH : Req0BH;
                rw_r   <= DDR3_CMD_READ;
            end else if ((state_r == ST_WR_HOLD) && go_write_s) begin
                rw_r   <= DDR3_CMD_WRITE;
            end else begin
                rw_r   <= rw_r;
            end
        end
    end

    // Early WriteGo is remembered only for the access in flight, so it cannot leak into the next one
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wgo_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RD_ISSUE, ST_RD_WAIT, ST_WR_HOLD: wgo_r <= wgo_r | WriteGo;
                default:                             wgo_r <= 1'b0;
            endcase
        end
    end

    assign Req0Ready = gnt0_s;
    assign Req1Ready = gnt1_s;
    assign AG_Start  = start_s;
    assign AG_RW     = rw_r;
    assign AG_BH     = bh_r;
    assign AG_Leaf   = leaf_r;
    assign Busy      = (state_r != ST_IDLE);
    assign GrantId   = owner_s;
    assign AccDone   = done_r;

endmodule

// File: tb/tb_path_addr_sched.sv
// Self-checking bench for path_addr_sched: a generator model answers AG_Start, and
// expected commands/grants are queued when requests are driven and checked against observations.
module tb_path_addr_sched;

    logic       Clock, Reset;
    logic       Req0Valid, Req0Ready, Req0BH, Req1Valid, Req1Ready, Req1BH;
    logic [9:0] Req0Leaf, Req1Leaf, AG_Leaf;
    logic       AG_Start, AG_RW, AG_BH, AG_Ready, WriteGo, Busy, GrantId, AccDone;

    int errors = 0, checks = 0, cyc = 0, acc_cnt = 0, dbl = 0, busy = 0, model_last = 0;
    bit start_seen = 1'b0, ag_hold = 1'b0;
    logic [11:0] exp_cmd[$], obs_cmd[$];
    int obs_cyc[$], exp_gnt[$], obs_gnt[$];

    path_addr_sched #(.ORAML(10), .GuardCyc(1)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Leaf(Req0Leaf), .Req0BH(Req0BH),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Leaf(Req1Leaf), .Req1BH(Req1BH),
        .AG_Start(AG_Start), .AG_RW(AG_RW), .AG_BH(AG_BH), .AG_Leaf(AG_Leaf),
        .AG_Ready(AG_Ready), .WriteGo(WriteGo), .Busy(Busy), .GrantId(GrantId), .AccDone(AccDone)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: samples mid-cycle and records starts, grants and completions
    initial forever begin
        @(negedge Clock);
        cyc++;
        start_seen = AG_Start;
        if (AG_Start) begin
            obs_cmd.push_back({AG_RW, AG_BH, AG_Leaf});
            obs_cyc.push_back(cyc);
        end
        if (AccDone) acc_cnt++;
        if (Req0Ready) obs_gnt.push_back(0);
        if (Req1Ready) obs_gnt.push_back(1);
        if (Req0Ready && Req1Ready) dbl++;
    end

    // Address generator model: Ready drops the cycle after Start and returns 4 cycles later
    initial forever begin
        @(posedge Clock);
        #1;
        if (Reset) busy = 0;
        else if (start_seen) busy = 4;
        else if (busy > 0) busy--;
    end

    always_comb AG_Ready = (busy == 0) && !ag_hold;

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic do_req(input int port, input logic [9:0] leaf, input logic bh);
        int n = 0;
        bit got = 1'b0;
        @(posedge Clock);
        #1;
        if (port == 0) begin Req0Valid = 1'b1; Req0Leaf = leaf; Req0BH = bh; end
        else           begin Req1Valid = 1'b1; Req1Leaf = leaf; Req1BH = bh; end
        while (!got && n < 300) begin
            @(negedge Clock);
            n++;
            got = (port == 0) ? Req0Ready : Req1Ready;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL req_timeout port%0d: Ready=0 after %0d cycles, required 1", port, n);
        end
        @(posedge Clock);
        #1;
        if (port == 0) Req0Valid = 1'b0;
        else           Req1Valid = 1'b0;
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 500) begin
            @(negedge Clock);
            n++;
        end
        if (acc_cnt < target) begin
            checks++; errors++;
            $display("FAIL acc_timeout: AccDone count %0d, required %0d", acc_cnt, target);
        end
        wait_cycles(3);
    endtask

    task automatic clear_queues();
        exp_cmd.delete(); obs_cmd.delete(); obs_cyc.delete();
        exp_gnt.delete(); obs_gnt.delete();
    endtask

    task automatic test_reset();
        Reset = 1'b1; Req0Valid = 1'b0; Req1Valid = 1'b0; WriteGo = 1'b0;
        Req0Leaf = '0; Req1Leaf = '0; Req0BH = 1'b0; Req1BH = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if ({Req0Ready, Req1Ready, AG_Start, AG_RW, AG_BH, AG_Leaf, Busy, GrantId, AccDone} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {Req0Ready, Req1Ready, AG_Start, AG_RW, AG_BH, AG_Leaf, Busy, GrantId, AccDone});
        end
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        wait_cycles(2);
        clear_queues();
        model_last = 0;
    endtask

    task automatic test_basic();
        int acc0;
        logic [11:0] e, o;
        clear_queues();
        acc0 = acc_cnt;
        WriteGo = 1'b1;
        exp_cmd.push_back({1'b1, 1'b0, 10'h155});
        exp_cmd.push_back({1'b0, 1'b0, 10'h155});
        exp_gnt.push_back(0);
        do_req(0, 10'h155, 1'b0);
        model_last = 0;
        wait_acc(acc0 + 1);
        WriteGo = 1'b0;
        while (exp_cmd.size() > 0) begin
            e = exp_cmd.pop_front();
            checks++;
            if (obs_cmd.size() == 0) begin errors++; $display("FAIL basic_cmd: got none required %h", e); end
            else begin
                o = obs_cmd.pop_front();
                if (o !== e) begin errors++; $display("FAIL basic_cmd: got %h required %h", o, e); end
            end
        end
        checks++;
        if (obs_cmd.size() != 0) begin errors++; $display("FAIL basic_extra_start: got %0d extra required 0", obs_cmd.size()); end
        checks++;
        if (acc_cnt - acc0 != 1) begin errors++; $display("FAIL basic_accdone: got %0d pulses required 1", acc_cnt - acc0); end
        checks++;
        if (obs_gnt.size() != 1 || obs_gnt[0] != exp_gnt[0]) begin
            errors++; $display("FAIL basic_grant: got %0d grants required one grant to port 0", obs_gnt.size());
        end
    endtask

    task automatic test_writego_late();
        int acc0, n, w, c;
        logic [11:0] o;
        clear_queues();
        acc0 = acc_cnt;
        WriteGo = 1'b0;
        do_req(0, 10'h0AA, 1'b0);
        model_last = 0;
        n = 0;
        while (obs_cmd.size() == 0 && n < 100) begin @(negedge Clock); n++; end
        wait_cycles(25);
        checks++;
        if (obs_cmd.size() != 1 || Busy !== 1'b1 || acc_cnt != acc0) begin
            errors++;
            $display("FAIL hold_wait: starts=%0d Busy=%b acc=%0d required starts=1 Busy=1 acc=%0d",
                     obs_cmd.size(), Busy, acc_cnt, acc0);
        end
        WriteGo = 1'b1;
        w = cyc + 1;
        wait_cycles(1);
        WriteGo = 1'b0;
        wait_acc(acc0 + 1);
        checks++;
        if (obs_cmd.size() != 2) begin
            errors++; $display("FAIL late_starts: got %0d starts required 2", obs_cmd.size());
        end else begin
            void'(obs_cmd.pop_front()); void'(obs_cyc.pop_front());
            o = obs_cmd.pop_front(); c = obs_cyc.pop_front();
            if (o !== {1'b0, 1'b0, 10'h0AA} || c != w + 1) begin
                errors++;
                $display("FAIL late_write: got cmd %h at cycle %0d required %h at cycle %0d", o, c, {1'b0, 1'b0, 10'h0AA}, w + 1);
            end
        end
    endtask

    task automatic test_max_leaf();
        int acc0;
        logic [11:0] e, o;
        clear_queues();
        acc0 = acc_cnt;
        WriteGo = 1'b1;
        exp_cmd.push_back({1'b1, 1'b1, 10'h3FF});
        exp_cmd.push_back({1'b0, 1'b1, 10'h3FF});
        do_req(1, 10'h3FF, 1'b1);
        model_last = 1;
        checks++;
        if (GrantId !== 1'b1 || Busy !== 1'b1) begin
            errors++; $display("FAIL maxleaf_owner: GrantId=%b Busy=%b required 1 1", GrantId, Busy);
        end
        wait_acc(acc0 + 1);
        WriteGo = 1'b0;
        while (exp_cmd.size() > 0) begin
            e = exp_cmd.pop_front();
            checks++;
            if (obs_cmd.size() == 0) begin errors++; $display("FAIL maxleaf_cmd: got none required %h", e); end
            else begin
                o = obs_cmd.pop_front();
                if (o !== e) begin errors++; $display("FAIL maxleaf_cmd: got %h required %h", o, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc0, n, g, eg, og;
        logic [11:0] e, o;
        clear_queues();
        acc0 = acc_cnt;
        WriteGo = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef PATHSCHED_RR_EN
            g = (model_last == 0) ? 1 : 0;
`else
            g = 0;
`endif
            model_last = g;
            exp_gnt.push_back(g);
            exp_cmd.push_back((g == 0) ? {1'b1, 1'b0, 10'h011} : {1'b1, 1'b1, 10'h322});
            exp_cmd.push_back((g == 0) ? {1'b0, 1'b0, 10'h011} : {1'b0, 1'b1, 10'h322});
        end
        @(posedge Clock);
        #1;
        Req0Valid = 1'b1; Req0Leaf = 10'h011; Req0BH = 1'b0;
        Req1Valid = 1'b1; Req1Leaf = 10'h322; Req1BH = 1'b1;
        n = 0;
        while (obs_gnt.size() < 4 && n < 400) begin @(negedge Clock); n++; end
        @(posedge Clock);
        #1;
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        wait_acc(acc0 + 4);
        WriteGo = 1'b0;
        while (exp_gnt.size() > 0) begin
            eg = exp_gnt.pop_front();
            checks++;
            if (obs_gnt.size() == 0) begin errors++; $display("FAIL b2b_grant: got none required %0d", eg); end
            else begin
                og = obs_gnt.pop_front();
                if (og != eg) begin errors++; $display("FAIL b2b_grant: got %0d required %0d", og, eg); end
            end
        end
        while (exp_cmd.size() > 0) begin
            e = exp_cmd.pop_front();
            checks++;
            if (obs_cmd.size() == 0) begin errors++; $display("FAIL b2b_cmd: got none required %h", e); end
            else begin
                o = obs_cmd.pop_front();
                if (o !== e) begin errors++; $display("FAIL b2b_cmd: got %h required %h", o, e); end
            end
        end
        checks++;
        if (dbl != 0) begin errors++; $display("FAIL b2b_dual_ready: got %0d cycles required 0", dbl); end
    endtask

    task automatic test_ready_stall();
        int acc0, r, c;
        logic [11:0] o;
        clear_queues();
        acc0 = acc_cnt;
        WriteGo = 1'b1;
        ag_hold = 1'b1;
        do_req(0, 10'h1E7, 1'b0);
        model_last = 0;
        wait_cycles(50);
        checks++;
        if (obs_cmd.size() != 0) begin errors++; $display("FAIL stall_no_start: got %0d starts required 0", obs_cmd.size()); end
        ag_hold = 1'b0;
        r = cyc + 1;
        wait_acc(acc0 + 1);
        WriteGo = 1'b0;
        checks++;
        if (obs_cmd.size() == 0) begin
            errors++; $display("FAIL stall_release: got no start required one at cycle %0d", r);
        end else begin
            o = obs_cmd.pop_front(); c = obs_cyc.pop_front();
            if (o !== {1'b1, 1'b0, 10'h1E7} || c != r) begin
                errors++;
                $display("FAIL stall_release: got %h at cycle %0d required %h at cycle %0d", o, c, {1'b1, 1'b0, 10'h1E7}, r);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int acc0, n;
        logic [11:0] e, o;
        clear_queues();
        acc0 = acc_cnt;
        WriteGo = 1'b1;
        do_req(0, 10'h2C3, 1'b0);
        n = 0;
        while (obs_cmd.size() == 0 && n < 100) begin @(negedge Clock); n++; end
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        model_last = 0;
        @(negedge Clock);
        checks++;
        if ({AG_Start, AG_RW, AG_BH, AG_Leaf, Busy, GrantId, AccDone} !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b required all zero",
                     {AG_Start, AG_RW, AG_BH, AG_Leaf, Busy, GrantId, AccDone});
        end
        wait_cycles(15);
        checks++;
        if (acc_cnt != acc0 || obs_cmd.size() != 1) begin
            errors++; $display("FAIL midreset_abandon: acc=%0d starts=%0d required acc=%0d starts=1", acc_cnt, obs_cmd.size(), acc0);
        end
        clear_queues();
        exp_cmd.push_back({1'b1, 1'b1, 10'h0F0});
        exp_cmd.push_back({1'b0, 1'b1, 10'h0F0});
        do_req(0, 10'h0F0, 1'b1);
        wait_acc(acc0 + 1);
        WriteGo = 1'b0;
        while (exp_cmd.size() > 0) begin
            e = exp_cmd.pop_front();
            checks++;
            if (obs_cmd.size() == 0) begin errors++; $display("FAIL postreset_cmd: got none required %h", e); end
            else begin
                o = obs_cmd.pop_front();
                if (o !== e) begin errors++; $display("FAIL postreset_cmd: got %h required %h", o, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_writego_late();
        test_max_leaf();
        test_back_to_back();
        test_ready_stall();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
